// File: rtl/alu_issue_ctrl_if.sv
// Issue-controller bundle: instruction handshake, ALU operand bus and completion handshake.
// master = environment side (decoder, ALU, writeback); slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned OP_SIZE    = 6
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] rs_val;
    logic [ADDR_WIDTH-1:0] rt_val;
    logic [OP_SIZE-1:0]    alu_op;
    logic [ADDR_WIDTH-1:0] alu_in1;
    logic [ADDR_WIDTH-1:0] alu_in2;
    logic [ADDR_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  res_valid;
    logic                  res_ready;
    logic [ADDR_WIDTH-1:0] res_data;
    logic                  res_taken;
    logic                  res_illegal;

    modport master (
        output instr_valid, instr, rs_val, rt_val, alu_result, alu_zero, res_ready,
        input  instr_ready, alu_op, alu_in1, alu_in2, res_valid, res_data, res_taken, res_illegal
    );

    modport slave (
        input  instr_valid, instr, rs_val, rt_val, alu_result, alu_zero, res_ready,
        output instr_ready, alu_op, alu_in1, alu_in2, res_valid, res_data, res_taken, res_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes one instruction, holds it on the ALU bus for ALU_LAT cycles,
// captures the result and returns a completion. Optional HILO_CHECK_EN rejects stale MFHI/MFLO.
module alu_issue_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned OP_SIZE    = 6,
    parameter int unsigned ALU_LAT    = 2
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_ctrl_if.slave ctrl_io
);
    localparam logic [OP_SIZE-1:0] ALU_ADD  = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] ALU_SUB  = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] ALU_AND  = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] ALU_OR   = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] ALU_NOR  = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] ALU_SLT  = OP_SIZE'(5);
    localparam logic [OP_SIZE-1:0] ALU_SLL  = OP_SIZE'(6);
    localparam logic [OP_SIZE-1:0] ALU_SRL  = OP_SIZE'(7);
    localparam logic [OP_SIZE-1:0] ALU_MULT = OP_SIZE'(8);
    localparam logic [OP_SIZE-1:0] ALU_DIV  = OP_SIZE'(9);
    localparam logic [OP_SIZE-1:0] ALU_MFHI = OP_SIZE'(10);
    localparam logic [OP_SIZE-1:0] ALU_MFLO = OP_SIZE'(11);
    localparam logic [OP_SIZE-1:0] ALU_LUI  = OP_SIZE'(12);

    localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ALU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [OP_SIZE-1:0]    op_q, op_d;
    logic [ADDR_WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
    logic                  branch_q, branch_d, muldiv_q, muldiv_d;
    logic [ADDR_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_taken_q, res_taken_d, res_illegal_q, res_illegal_d;
    logic                  hilo_valid_q, hilo_valid_d;

    logic [5:0]            opcode, funct;
    logic [4:0]            shamt;
    logic [15:0]           imm;
    logic [ADDR_WIDTH-1:0] imm_sx, imm_zx;
    logic [OP_SIZE-1:0]    dec_op;
    logic [ADDR_WIDTH-1:0] dec_in1, dec_in2;
    logic                  dec_bad, dec_div0, dec_branch, dec_muldiv, dec_hilo_rd, dec_illegal;
    logic                  unused_instr;

    assign opcode       = ctrl_io.instr[31:26];
    assign funct        = ctrl_io.instr[5:0];
    assign shamt        = ctrl_io.instr[10:6];
    assign imm          = ctrl_io.instr[15:0];
    assign imm_sx       = ADDR_WIDTH'({{16{imm[15]}}, imm});
    assign imm_zx       = ADDR_WIDTH'({16'h0000, imm});
    assign unused_instr = ^ctrl_io.instr[25:16];

    always_comb begin
        dec_op      = ALU_ADD;
        dec_in1     = ctrl_io.rs_val;
        dec_in2     = ctrl_io.rt_val;
        dec_bad     = 1'b0;
        dec_div0    = 1'b0;
        dec_branch  = 1'b0;
        dec_muldiv  = 1'b0;
        dec_hilo_rd = 1'b0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20: dec_op = ALU_ADD;
                6'h22: dec_op = ALU_SUB;
                6'h24: dec_op = ALU_AND;
                6'h25: dec_op = ALU_OR;
                6'h27: dec_op = ALU_NOR;
                6'h2A: dec_op = ALU_SLT;
                6'h00, 6'h02: begin
                    dec_op  = (funct == 6'h00) ? ALU_SLL : ALU_SRL;
                    dec_in1 = ctrl_io.rt_val;
                    dec_in2 = ADDR_WIDTH'(shamt);
                end
                6'h18: begin
                    dec_op     = ALU_MULT;
                    dec_muldiv = 1'b1;
                end
                6'h1A: begin
                    dec_op     = ALU_DIV;
                    dec_muldiv = 1'b1;
                    dec_div0   = (ctrl_io.rt_val == '0);
                end
                6'h10, 6'h12: begin
                    dec_op      = (funct == 6'h10) ? ALU_MFHI : ALU_MFLO;
                    dec_hilo_rd = 1'b1;
                end
                default: dec_bad = 1'b1;
            endcase
        end else begin
            dec_in2 = imm_sx;
            case (opcode)
                6'h08, 6'h20, 6'h21, 6'h28, 6'h29: dec_op = ALU_ADD;
                6'h0C: begin
                    dec_op  = ALU_AND;
                    dec_in2 = imm_zx;
                end
                6'h0D: begin
                    dec_op  = ALU_OR;
                    dec_in2 = imm_zx;
                end
                6'h0F: begin
                    dec_op  = ALU_LUI;
                    dec_in2 = imm_zx;
                end
                6'h0A: dec_op = ALU_SLT;
                6'h04: begin
                    dec_op     = ALU_SUB;
                    dec_in2    = ctrl_io.rt_val;
                    dec_branch = 1'b1;
                end
                // BGEZ: SLT rs,0 yields zero exactly when rs is non-negative.
                6'h01: begin
                    dec_op     = ALU_SLT;
                    dec_in2    = '0;
                    dec_branch = 1'b1;
                end
                default: dec_bad = 1'b1;
            endcase
        end
    end

`ifdef HILO_CHECK_EN
    assign dec_illegal = dec_bad | dec_div0 | (dec_hilo_rd & ~hilo_valid_q);
`else
    logic unused_hilo_rd;
    assign unused_hilo_rd = dec_hilo_rd;
    assign dec_illegal    = dec_bad | dec_div0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        in1_d         = in1_q;
        in2_d         = in2_q;
        branch_d      = branch_q;
        muldiv_d      = muldiv_q;
        res_data_d    = res_data_q;
        res_taken_d   = res_taken_q;
        res_illegal_d = res_illegal_q;
        hilo_valid_d  = hilo_valid_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl_io.instr_valid) begin
                    op_d     = dec_op;
                    in1_d    = dec_in1;
                    in2_d    = dec_in2;
                    branch_d = dec_branch;
                    muldiv_d = dec_muldiv;
                    cnt_d    = '0;
                    if (dec_illegal) begin
                        state_d       = StResp;
                        res_data_d    = '0;
                        res_taken_d   = 1'b0;
                        res_illegal_d = 1'b1;
                        if (dec_div0) hilo_valid_d = 1'b0;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (cnt_q == CntLast) begin
                    state_d       = StResp;
                    res_data_d    = (branch_q | muldiv_q) ? '0 : ctrl_io.alu_result;
                    res_taken_d   = branch_q & ctrl_io.alu_zero;
                    res_illegal_d = 1'b0;
                    if (muldiv_q) hilo_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (ctrl_io.res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            op_q          <= ALU_ADD;
            in1_q         <= '0;
            in2_q         <= '0;
            branch_q      <= 1'b0;
            muldiv_q      <= 1'b0;
            res_data_q    <= '0;
            res_taken_q   <= 1'b0;
            res_illegal_q <= 1'b0;
            hilo_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            branch_q      <= branch_d;
            muldiv_q      <= muldiv_d;
            res_data_q    <= res_data_d;
            res_taken_q   <= res_taken_d;
            res_illegal_q <= res_illegal_d;
            hilo_valid_q  <= hilo_valid_d;
        end
    end

    // Bus is parked at ADD/0 outside ISSUE so MULT/DIV never re-write the product register.
    assign ctrl_io.alu_op      = (state_q == StIssue) ? op_q : ALU_ADD;
    assign ctrl_io.alu_in1     = (state_q == StIssue) ? in1_q : '0;
    assign ctrl_io.alu_in2     = (state_q == StIssue) ? in2_q : '0;
    assign ctrl_io.instr_ready = (state_q == StIdle);
    assign ctrl_io.res_valid   = (state_q == StResp);
    assign ctrl_io.res_data    = res_data_q;
    assign ctrl_io.res_taken   = res_taken_q;
    assign ctrl_io.res_illegal = res_illegal_q;
endmodule
